// File: rtl/mm_scheduler_if.sv
// rtl/mm_scheduler_if.sv - Bus bundle between mm_scheduler, key RAMs, mm datapath and accumulator
// master = scheduler side, slave = memories/datapath side.
interface mm_scheduler_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  pk_addr;
  logic [23:0] pk_rdata;
  logic [7:0]  sk_addr;
  logic [3:0]  sk_rdata;
  logic        mm_A_valid;
  logic [9:0]  mm_A_idx;
  logic [23:0] mm_pk_A;
  logic        mm_s_valid;
  logic [9:0]  mm_s_idx;
  logic [3:0]  mm_sk_s;
  logic        mm_B_ready;
  logic        mm_B_valid;
  logic [9:0]  mm_idx_B;
  logic [41:0] mm_B_out;
  logic [8:0]  acc_addr;
  logic [23:0] acc_rdata;
  logic [23:0] acc_wdata;
  logic        acc_we;

  modport master (
    input  start, pk_rdata, sk_rdata, mm_B_valid, mm_idx_B, mm_B_out, acc_rdata,
    output busy, done, pk_addr, sk_addr, mm_A_valid, mm_A_idx, mm_pk_A,
           mm_s_valid, mm_s_idx, mm_sk_s, mm_B_ready, acc_addr, acc_wdata, acc_we
  );

  modport slave (
    output start, pk_rdata, sk_rdata, mm_B_valid, mm_idx_B, mm_B_out, acc_rdata,
    input  busy, done, pk_addr, sk_addr, mm_A_valid, mm_A_idx, mm_pk_A,
           mm_s_valid, mm_s_idx, mm_sk_s, mm_B_ready, acc_addr, acc_wdata, acc_we
  );
endinterface

// File: rtl/mm_scheduler.sv
// rtl/mm_scheduler.sv - Schedules chunked A*s polynomial product through the mm datapath
// Outer loop over s chunks j, inner over A chunks i; a 3-coeff carry window folds partial products.
module mm_scheduler #(
  parameter int DEPTH = 784
) (
  input logic            clk_in,
  input logic            rst_in,
  mm_scheduler_if.master bus
);
  localparam int         N          = DEPTH / 4;
  localparam logic [7:0] LAST_CHUNK = 8'(N - 1);
  localparam logic [8:0] N_CHUNKS   = 9'(N);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_S, S_FETCH_A, S_ISSUE, S_WAIT_B, S_ACC_WR, S_FLUSH, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [3:0]  s_q, s_d;
  logic [17:0] c_q, c_d;
  logic [23:0] l_q, l_d;

  logic [8:0]  ij_sum;
  logic [9:0]  b_idx_exp;

  function automatic logic [23:0] add_coeffs(input logic [23:0] x, input logic [23:0] y);
    logic [23:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[6*k +: 6] = x[6*k +: 6] + y[6*k +: 6];
    end
    return r;
  endfunction

  assign ij_sum    = {1'b0, i_q} + {1'b0, j_q};
  // Index field is 10 bits wide; the match uses the low bits of 4*(i+j).
  assign b_idx_exp = {ij_sum[7:0], 2'b00};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
      l_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      s_q     <= s_d;
      c_q     <= c_d;
      l_q     <= l_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    i_d            = i_q;
    j_d            = j_q;
    s_d            = s_q;
    c_d            = c_q;
    l_d            = l_q;
    bus.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    bus.done       = 1'b0;
    bus.pk_addr    = '0;
    bus.sk_addr    = '0;
    bus.mm_A_valid = 1'b0;
    bus.mm_A_idx   = '0;
    bus.mm_pk_A    = '0;
    bus.mm_s_valid = 1'b0;
    bus.mm_s_idx   = '0;
    bus.mm_sk_s    = '0;
    bus.mm_B_ready = 1'b0;
    bus.acc_addr   = '0;
    bus.acc_wdata  = '0;
    bus.acc_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          j_d     = '0;
          state_d = S_LOAD_S;
        end
      end
      S_LOAD_S: begin
        bus.sk_addr = j_q;
        c_d         = '0;
        i_d         = '0;
        state_d     = S_FETCH_A;
      end
      S_FETCH_A: begin
        if (i_q == '0) s_d = bus.sk_rdata;
        bus.pk_addr = i_q;
        state_d     = S_ISSUE;
      end
      S_ISSUE: begin
        bus.mm_A_valid = 1'b1;
        bus.mm_A_idx   = {i_q, 2'b00};
        bus.mm_pk_A    = bus.pk_rdata;
        bus.mm_s_valid = 1'b1;
        bus.mm_s_idx   = {j_q, 2'b00};
        bus.mm_sk_s    = s_q;
        bus.acc_addr   = ij_sum;
        state_d        = S_WAIT_B;
      end
      S_WAIT_B: begin
        bus.mm_B_ready = 1'b1;
        bus.acc_addr   = ij_sum;
        // A sticky valid carrying an older index must not be consumed.
        if (bus.mm_B_valid && (bus.mm_idx_B == b_idx_exp)) begin
          l_d     = add_coeffs({6'd0, c_q}, bus.mm_B_out[23:0]);
          c_d     = bus.mm_B_out[41:24];
          state_d = S_ACC_WR;
        end
      end
      S_ACC_WR: begin
        bus.acc_we    = 1'b1;
        bus.acc_addr  = ij_sum;
        bus.acc_wdata = (j_q == '0) ? l_q : add_coeffs(bus.acc_rdata, l_q);
        if (i_q == LAST_CHUNK) begin
          state_d = S_FLUSH;
        end else begin
          i_d     = i_q + 8'd1;
          state_d = S_FETCH_A;
        end
      end
      S_FLUSH: begin
        bus.acc_we    = 1'b1;
        bus.acc_addr  = {1'b0, j_q} + N_CHUNKS;
        bus.acc_wdata = {6'd0, c_q};
        if (j_q == LAST_CHUNK) begin
          state_d = S_DONE;
        end else begin
          j_d     = j_q + 8'd1;
          state_d = S_LOAD_S;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mm_scheduler.sv
// tb/tb_mm_scheduler.sv - Self-checking bench for mm_scheduler with RAM and mm datapath models
module tb_mm_scheduler;
  localparam int DEPTH = 16;
  localparam int N     = DEPTH / 4;
  localparam int NC    = 2 * N;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mm_scheduler_if bus();
  mm_scheduler #(.DEPTH(DEPTH)) dut (.clk_in(clk), .rst_in(rst_n), .bus(bus));

  typedef struct {
    logic [95:0] a;
    logic [15:0] s;
    bit          stale;
    bit          dbl_start;
  } vec_t;

  typedef struct {
    logic [8:0] addr;
    bit         flush;
  } wr_t;

  int checks = 0;
  int errors = 0;

  logic [23:0] pk_mem [N];
  logic [3:0]  sk_mem [N];
  logic [23:0] acc_mem[NC];
  wr_t         wr_q[$];
  logic [23:0] res_q[$];
  vec_t        vecs[5];
  bit          stale_mode = 1'b0;

  always @(posedge clk) begin
    bus.pk_rdata  <= pk_mem[bus.pk_addr[1:0]];
    bus.sk_rdata  <= sk_mem[bus.sk_addr[1:0]];
    bus.acc_rdata <= acc_mem[bus.acc_addr[2:0]];
    if (bus.acc_we) acc_mem[bus.acc_addr[2:0]] <= bus.acc_wdata;
  end

  function automatic logic [41:0] mul_chunk(input logic [23:0] a, input logic [3:0] s);
    logic [41:0] r;
    r = '0;
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        if (s[y]) r[6*(x+y) +: 6] = r[6*(x+y) +: 6] + a[6*x +: 6];
    return r;
  endfunction

  logic [9:0]  hold_idx;
  logic [41:0] hold_out;
  int          stale_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mm_B_valid <= 1'b0;
      bus.mm_idx_B   <= '0;
      bus.mm_B_out   <= '0;
      hold_idx       <= '0;
      hold_out       <= '0;
      stale_cnt      <= 0;
    end else if (bus.mm_A_valid) begin
      bus.mm_B_valid <= 1'b1;
      if (stale_mode) begin
        bus.mm_idx_B <= bus.mm_A_idx + bus.mm_s_idx + 10'd4;
        bus.mm_B_out <= ~mul_chunk(bus.mm_pk_A, bus.mm_sk_s);
        hold_idx     <= bus.mm_A_idx + bus.mm_s_idx;
        hold_out     <= mul_chunk(bus.mm_pk_A, bus.mm_sk_s);
        stale_cnt    <= 3;
      end else begin
        bus.mm_idx_B <= bus.mm_A_idx + bus.mm_s_idx;
        bus.mm_B_out <= mul_chunk(bus.mm_pk_A, bus.mm_sk_s);
        stale_cnt    <= 0;
      end
    end else if (stale_cnt != 0) begin
      stale_cnt <= stale_cnt - 1;
      if (stale_cnt == 1) begin
        bus.mm_idx_B <= hold_idx;
        bus.mm_B_out <= hold_out;
      end
    end
  end

  function automatic logic [191:0] ref_mul(input logic [95:0] a, input logic [15:0] s);
    logic [191:0] r;
    r = '0;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        if (s[y]) r[6*(x+y) +: 6] = r[6*(x+y) +: 6] + a[6*x +: 6];
    return r;
  endfunction

  function automatic logic [5:0] coef(input int n);
    logic [23:0] c;
    c = acc_mem[n / 4];
    return c[6*(n % 4) +: 6];
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_addrs"}, {bus.pk_addr, bus.sk_addr, bus.acc_addr}, 0);
    chk({tag, "_strobes"}, {bus.mm_A_valid, bus.mm_s_valid, bus.mm_B_ready, bus.acc_we}, 0);
    chk({tag, "_data"}, {bus.acc_wdata, bus.mm_pk_A, bus.mm_sk_s}, 0);
    chk({tag, "_idx"}, {bus.mm_A_idx, bus.mm_s_idx}, 0);
  endtask

  task automatic run_vec(input vec_t v, input bit abort_p2);
    logic [191:0] exp_r;
    wr_t w;
    int  cyc, t_issue, dones, writes;
    bit  fin;
    for (int c = 0; c < N; c++) begin
      pk_mem[c] = v.a[24*c +: 24];
      sk_mem[c] = v.s[4*c +: 4];
    end
    stale_mode = v.stale;
    exp_r = ref_mul(v.a, v.s);
    wr_q.delete();
    res_q.delete();
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) wr_q.push_back('{addr: 9'(i + j), flush: 1'b0});
      wr_q.push_back('{addr: 9'(j + N), flush: 1'b1});
    end
    for (int c = 0; c < NC; c++) res_q.push_back(exp_r[24*c +: 24]);

    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    cyc = 0; t_issue = 0; dones = 0; writes = 0; fin = 1'b0;
    while (!fin && cyc < 3000) begin
      if (bus.mm_A_valid) t_issue = cyc;
      if (bus.acc_we) begin
        writes++;
        if (wr_q.size() != 0) w = wr_q.pop_front();
        else begin w.addr = '1; w.flush = 1'b0; end
        chk("acc_addr", bus.acc_addr, w.addr);
        if (!w.flush) chk("b_latency", cyc - t_issue, v.stale ? 5 : 2);
      end
      if (bus.done) begin
        dones++;
        chk("busy_at_done", bus.busy, 0);
        fin = 1'b1;
      end
      if (v.dbl_start) bus.start = (cyc == 7);
      if (abort_p2 && writes == N + 1 && bus.mm_B_ready) begin
        #2 rst_n = 1'b0;
        #1 check_quiet("midreset");
        return;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk("run_finished", fin, 1);
    repeat (4) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("done_count", dones, 1);
    chk("busy_after", bus.busy, 0);
    chk("writes_left", wr_q.size(), 0);
    for (int c = 0; c < NC; c++) chk($sformatf("acc_chunk%0d", c), acc_mem[c], res_q.pop_front());
  endtask

  initial begin
    logic [95:0] ramp;
    bus.start = 1'b0;
    for (int k = 0; k < 16; k++) ramp[6*k +: 6] = 6'(k * 5 + 3);
    vecs[0] = '{a: {16{6'd1}},  s: 16'h0001, stale: 1'b0, dbl_start: 1'b0};
    vecs[1] = '{a: {16{6'd63}}, s: 16'hFFFF, stale: 1'b0, dbl_start: 1'b1};
    vecs[2] = '{a: ramp,        s: 16'hA5C3, stale: 1'b1, dbl_start: 1'b0};
    vecs[3] = '{a: ramp,        s: 16'hA5C3, stale: 1'b0, dbl_start: 1'b0};
    vecs[4] = '{a: {$urandom, $urandom, $urandom}, s: 16'($urandom), stale: 1'b0, dbl_start: 1'b1};

    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) run_vec(vecs[v], 1'b0);

    run_vec(vecs[0], 1'b0);
    for (int c = 0; c < N; c++)  chk($sformatf("ones_lo%0d", c), acc_mem[c], 24'h041041);
    for (int c = N; c < NC; c++) chk($sformatf("ones_hi%0d", c), acc_mem[c], 0);

    run_vec(vecs[1], 1'b0);
    chk("neg_c0",  coef(0),  63);
    chk("neg_c1",  coef(1),  62);
    chk("neg_c15", coef(15), 48);
    chk("neg_c30", coef(30), 63);
    chk("neg_c31", coef(31), 0);

    run_vec(vecs[2], 1'b1);
    repeat (2) @(negedge clk);
    check_quiet("held_reset");
    rst_n = 1'b1;
    run_vec(vecs[2], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
